// File: rtl/fns_enc_seq_if.sv
// Handshake bundle for the Fibonacci-number-system encoder: binary word in,
// FNS codeword out.
interface fns_enc_seq_if #(
  parameter int CODE_W = 8,
  parameter int DATA_W = 6
);
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the source holds its payload steady while valid is high and ready is low.
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [CODE_W-1:0] code;
  logic              code_err;
  logic              code_valid;
  logic              code_ready;

  modport master (
    output din, din_valid, code_ready,
    input  din_ready, code, code_err, code_valid
  );

  modport slave (
    input  din, din_valid, code_ready,
    output din_ready, code, code_err, code_valid
  );
endinterface

// File: rtl/fns_enc_seq.sv
// Sequential greedy FNS encoder: one codeword bit per cycle, MSB first,
// stepping the Fibonacci weight pair downwards by subtraction.
module fns_enc_seq #(
  parameter int CODE_W = 8,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  fns_enc_seq_if.slave      bus,
  output logic [1:0]        o_dbg_state
);

  function automatic int fns_w(input int k);
    int a, b, t;
    a = 1;
    b = 1;
    for (int i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int fns_vmax(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += fns_w(i);
    return s;
  endfunction

  localparam int              VMAX   = fns_vmax(CODE_W);
  localparam int              RW     = $clog2(VMAX + 1);
  localparam int              KW     = $clog2(CODE_W);
  localparam logic [RW-1:0]   W_TOP  = RW'(fns_w(CODE_W - 1));
  localparam logic [RW-1:0]   W_NXT  = RW'(fns_w(CODE_W - 2));
  localparam logic [KW-1:0]   K_TOP  = KW'(CODE_W - 1);
  localparam logic [31:0]     VMAX_U = 32'(VMAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [RW-1:0]     r_rem;
  logic [RW-1:0]     r_wk;
  logic [RW-1:0]     r_wk1;
  logic [KW-1:0]     r_k;
  logic [CODE_W-1:0] r_code;
  logic              r_err;
  logic [31:0]       w_din_ext;
  logic              w_in_range;
  logic              w_take;

  assign w_din_ext  = 32'(bus.din);
  assign w_in_range = (w_din_ext <= VMAX_U);
  assign w_take     = (r_rem >= r_wk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.din_valid) w_next = w_in_range ? S_ENC : S_HOLD;
      S_ENC:  if (r_k == '0)     w_next = S_HOLD;
      S_HOLD: if (bus.code_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.din_ready  = (r_state == S_IDLE);
    bus.code_valid = (r_state == S_HOLD);
    bus.code       = r_code;
    bus.code_err   = r_err;
    o_dbg_state    = r_state;
  end

  // Weight pair (wk, w(k-1)) walks down to (w(k-1), wk - w(k-1)); wk >= w(k-1)
  // always holds, so neither subtraction can wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_wk   <= W_TOP;
      r_wk1  <= W_NXT;
      r_k    <= K_TOP;
      r_code <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.din_valid) begin
            r_code <= '0;
            r_k    <= K_TOP;
            r_wk   <= W_TOP;
            r_wk1  <= W_NXT;
            r_err  <= !w_in_range;
            r_rem  <= w_in_range ? RW'(bus.din) : '0;
          end
        end
        S_ENC: begin
          r_code[r_k] <= w_take;
          if (w_take) r_rem <= r_rem - r_wk;
          r_wk  <= r_wk1;
          r_wk1 <= r_wk - r_wk1;
          r_k   <= (r_k == '0) ? K_TOP : r_k - KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fns_enc_seq.sv
// Directed plus randomized bench for fns_enc_seq against a greedy FNS model.
module tb_fns_enc_seq;
  localparam int CODE_W = 8;
  localparam int DATA_W = 6;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int w_tab[CODE_W];
  int vmax;
  logic [CODE_W-1:0] exp_q[$];

  fns_enc_seq_if #(.CODE_W(CODE_W), .DATA_W(DATA_W)) bus ();

  fns_enc_seq #(.CODE_W(CODE_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: largest-weight-first greedy over the Fibonacci weight table.
  function automatic logic [CODE_W-1:0] ref_code(input int v);
    logic [CODE_W-1:0] c;
    int rem;
    c = '0;
    if (v > vmax) return c;
    rem = v;
    for (int k = CODE_W - 1; k >= 0; k--) begin
      if (rem >= w_tab[k]) begin
        c[k] = 1'b1;
        rem -= w_tab[k];
      end
    end
    return c;
  endfunction

  function automatic int decode(input logic [CODE_W-1:0] c);
    int s;
    s = 0;
    for (int k = 0; k < CODE_W; k++) if (c[k]) s += w_tab[k];
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input int v, input int hold_n);
    int waited;
    int lat;
    logic [CODE_W-1:0] exp_c;
    logic exp_e;
    exp_e = (v > vmax);
    exp_c = ref_code(v);
    waited = 0;
    while (!bus.din_ready && waited < 20) begin
      step();
      waited++;
    end
    check("ready_wait", 32'(bus.din_ready), 1);
    bus.din       = DATA_W'(v);
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    lat = 1;
    while (!bus.code_valid && lat < 20) begin
      bus.din        = DATA_W'($urandom);
      bus.din_valid  = 1'($urandom_range(0, 1));
      bus.code_ready = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    bus.din_valid  = 1'b0;
    bus.code_ready = 1'b0;
    check("latency", lat, exp_e ? 1 : CODE_W + 1);
    check("code", 32'(bus.code), 32'(exp_c));
    check("code_err", 32'(bus.code_err), 32'(exp_e));
    if (!exp_e) check("decode", decode(bus.code), v);
    for (int i = 0; i < hold_n; i++) begin
      step();
      check("hold_valid", 32'(bus.code_valid), 1);
      check("hold_code", 32'(bus.code), 32'(exp_c));
      check("hold_err", 32'(bus.code_err), 32'(exp_e));
    end
    bus.code_ready = 1'b1;
    step();
    bus.code_ready = 1'b0;
    check("post_valid", 32'(bus.code_valid), 0);
    check("post_ready", 32'(bus.din_ready), 1);
  endtask

  initial begin
    int nxt;
    int cycle;
    int acc_t[$];
    logic acc_now;

    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.code_ready = 1'b0;
    w_tab[0] = 1;
    w_tab[1] = 1;
    for (int k = 2; k < CODE_W; k++) w_tab[k] = w_tab[k-1] + w_tab[k-2];
    vmax = 0;
    for (int k = 0; k < CODE_W; k++) vmax += w_tab[k];

    #1;
    check("rst_valid", 32'(bus.code_valid), 0);
    check("rst_ready", 32'(bus.din_ready), 1);
    check("rst_code", 32'(bus.code), 0);
    check("rst_err", 32'(bus.code_err), 0);
    #21 rst_n = 1'b1;

    // Directed values, including the maximum and an out-of-range word
    run_word(0, 0);
    run_word(7, 0);
    run_word(20, 1);
    run_word(54, 0);
    run_word(60, 2);
    run_word(7, 5);

    // Reset mid-encode, then resubmit the same value
    while (!bus.din_ready) step();
    bus.din       = DATA_W'(33);
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    step();
    step();
    step();
    check("mid_enc_msb", 32'(bus.code[CODE_W-1]), 32'(ref_code(33) >> (CODE_W - 1)));
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.code_valid), 0);
    check("arst_ready", 32'(bus.din_ready), 1);
    check("arst_code", 32'(bus.code), 0);
    check("arst_err", 32'(bus.code_err), 0);
    step();
    step();
    rst_n = 1'b1;
    run_word(33, 1);

    // Exhaustive sweep with random backpressure
    for (int v = 0; v < (1 << DATA_W); v++) run_word(v, int'($urandom_range(0, 3)));

    // Streaming with code_ready held high: scoreboard plus accept spacing
    nxt            = int'($urandom_range(0, vmax));
    bus.din        = DATA_W'(nxt);
    bus.din_valid  = 1'b1;
    bus.code_ready = 1'b1;
    cycle          = 0;
    repeat (40) begin
      acc_now = bus.din_ready;
      if (acc_now) begin
        exp_q.push_back(ref_code(nxt));
        acc_t.push_back(cycle);
      end
      if (bus.code_valid) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_code", 32'(bus.code), 32'(exp_q.pop_front()));
      end
      step();
      cycle++;
      if (acc_now) begin
        nxt     = int'($urandom_range(0, vmax));
        bus.din = DATA_W'(nxt);
      end
    end
    bus.din_valid  = 1'b0;
    bus.code_ready = 1'b0;
    check("sb_drained", exp_q.size(), 0);
    check("stream_accepts", acc_t.size(), 40 / (CODE_W + 2));
    for (int i = 1; i < acc_t.size(); i++)
      check("throughput", acc_t[i] - acc_t[i-1], CODE_W + 2);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
